// File: rtl/adc128s_model.sv
// SPI slave model of an 8-channel 12-bit A2D converter. Each channel returns a fixed value.
// The word returned in a frame belongs to the channel addressed in the previous complete frame.
module adc128s_model #(
  parameter logic [11:0] CH0_VAL = 12'h000,
  parameter logic [11:0] CH1_VAL = 12'h000,
  parameter logic [11:0] CH2_VAL = 12'h800,
  parameter logic [11:0] CH3_VAL = 12'h000,
  parameter logic [11:0] CH4_VAL = 12'h000,
  parameter logic [11:0] CH5_VAL = 12'hFFF,
  parameter logic [11:0] CH6_VAL = 12'h000,
  parameter logic [11:0] CH7_VAL = 12'h000
) (
  input  logic clk,
  input  logic rst,
  input  logic SS_n,
  input  logic SCLK,
  input  logic MOSI,
  output logic MISO
);

  logic [2:0]  ss_sync;
  logic [2:0]  sclk_sync;
  logic [1:0]  mosi_sync;
  logic [2:0]  addr;
  logic [15:0] tx_shft;
  logic [15:0] rx_shft;
  logic [4:0]  bit_cnt;

  logic ss_low, frame_start, frame_end, sclk_rise, sclk_fall;
  logic [11:0] ch_val;

  // Stage [1] is the synchronized value; stage [2] is kept only for edge detection.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ss_sync   <= 3'b111;
      sclk_sync <= 3'b111;
      mosi_sync <= 2'b00;
    end else begin
      ss_sync   <= {ss_sync[1:0], SS_n};
      sclk_sync <= {sclk_sync[1:0], SCLK};
      mosi_sync <= {mosi_sync[0], MOSI};
    end
  end

  assign ss_low      = ~ss_sync[1];
  assign frame_start =  ss_sync[2] & ~ss_sync[1];
  assign frame_end   = ~ss_sync[2] &  ss_sync[1];
  assign sclk_rise   = ~sclk_sync[2] &  sclk_sync[1];
  assign sclk_fall   =  sclk_sync[2] & ~sclk_sync[1];

  always_comb begin
    ch_val = CH0_VAL;
    case (addr)
      3'd0: ch_val = CH0_VAL;
      3'd1: ch_val = CH1_VAL;
      3'd2: ch_val = CH2_VAL;
      3'd3: ch_val = CH3_VAL;
      3'd4: ch_val = CH4_VAL;
      3'd5: ch_val = CH5_VAL;
      3'd6: ch_val = CH6_VAL;
      default: ch_val = CH7_VAL;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      addr    <= 3'd0;
      tx_shft <= 16'h0000;
      rx_shft <= 16'h0000;
      bit_cnt <= 5'd0;
    end else if (frame_start) begin
      tx_shft <= {4'b0000, ch_val};
      bit_cnt <= 5'd0;
    end else if (frame_end) begin
      tx_shft <= 16'h0000;
    end else if (ss_low) begin
      if (sclk_rise) begin
        rx_shft <= (rx_shft << 1) | {15'd0, mosi_sync[1]};
        if (bit_cnt != 5'd16)
          bit_cnt <= bit_cnt + 5'd1;
        // On the 16th rise the command's bits 13:11 sit one position lower, pre-shift.
        if (bit_cnt == 5'd15)
          addr <= rx_shft[12:10];
      end
      // The fall before the first rise must not shift: bit 15 is presented from SS_n fall.
      if (sclk_fall && bit_cnt != 5'd0)
        tx_shft <= tx_shft << 1;
    end
  end

  assign MISO = tx_shft[15];

endmodule

// File: tb/tb_adc128s_model.sv
// Bench for adc128s_model: an SPI master drives frames; a channel-table model predicts each word.
module tb_adc128s_model;

  logic clk = 1'b0;
  logic rst, SS_n, SCLK, MOSI, MISO;

  int vectors = 0;
  int errors  = 0;

  logic [11:0] ch_val [8] = '{12'h000, 12'h000, 12'h800, 12'h000,
                              12'h000, 12'hFFF, 12'h000, 12'hA5C};
  logic [2:0] m_addr = 3'd0;

  always #5 clk = ~clk;

  adc128s_model #(.CH7_VAL(12'hA5C)) dut (
    .clk(clk), .rst(rst), .SS_n(SS_n), .SCLK(SCLK), .MOSI(MOSI), .MISO(MISO)
  );

  function automatic logic [15:0] make_cmd(input logic [2:0] a);
    logic [15:0] c;
    c = 16'($urandom);
    c[13:11] = a;
    return c;
  endfunction

  // Full master transaction; expected word comes from the previously latched channel.
  task automatic spi_frame(input logic [15:0] cmd, input int nbits, input int half);
    logic [15:0] rx, exp_w, mask;
    logic extra_bad;
    int n;
    rx = 16'h0;
    extra_bad = 1'b0;
    @(negedge clk);
    SS_n = 1'b0;
    repeat (half) @(negedge clk);
    for (int i = 0; i < nbits; i++) begin
      SCLK = 1'b0;
      MOSI = (i < 16) ? cmd[15-i] : 1'($urandom_range(0, 1));
      repeat (half) @(negedge clk);
      if (i < 16) rx[15-i] = MISO;
      else if (MISO !== 1'b0) extra_bad = 1'b1;
      SCLK = 1'b1;
      repeat (half) @(negedge clk);
    end
    SS_n = 1'b1;
    repeat (6) @(negedge clk);

    n = (nbits < 16) ? nbits : 16;
    mask = 16'hFFFF << (16 - n);
    exp_w = {4'h0, ch_val[m_addr]};
    vectors++;
    if ((rx & mask) !== (exp_w & mask)) begin
      errors++;
      $display("FAIL frame_word cmd=%h bits=%0d got=%h expected=%h", cmd, nbits, rx & mask, exp_w & mask);
    end
    if (nbits > 16) begin
      vectors++;
      if (extra_bad !== 1'b0) begin
        errors++;
        $display("FAIL extra_bits got=nonzero expected=0");
      end
    end
    vectors++;
    if (MISO !== 1'b0) begin
      errors++;
      $display("FAIL miso_idle got=%b expected=0", MISO);
    end
    if (nbits >= 16) m_addr = cmd[13:11];
  endtask

  task automatic do_reset();
    rst = 1'b1; SS_n = 1'b1; SCLK = 1'b1; MOSI = 1'b0;
    repeat (4) @(negedge clk);
    rst = 1'b0;
    m_addr = 3'd0;
    repeat (4) @(negedge clk);
  endtask

  task automatic test_reset();
    do_reset();
    vectors++;
    if (MISO !== 1'b0) begin
      errors++;
      $display("FAIL reset_miso got=%b expected=0", MISO);
    end
  endtask

  task automatic test_basic();
    spi_frame(make_cmd(3'd2), 16, 4);
    spi_frame(make_cmd(3'd5), 16, 5);
    spi_frame(make_cmd(3'd0), 16, 6);
    spi_frame(make_cmd(3'd0), 16, 4);
  endtask

  task automatic test_abort();
    spi_frame(make_cmd(3'd5), 16, 4);
    spi_frame(make_cmd(3'd3), 8, 4);
    spi_frame(make_cmd(3'd4), 16, 4);
    spi_frame(make_cmd(3'd1), 16, 4);
  endtask

  task automatic test_ch7();
    spi_frame(make_cmd(3'd7), 16, 4);
    spi_frame(make_cmd(3'($urandom_range(0, 7))), 16, 4);
  endtask

  task automatic test_long_frame();
    spi_frame(make_cmd(3'd5), 20, 4);
    spi_frame(make_cmd(3'd2), 16, 4);
  endtask

  task automatic test_reset_mid();
    logic [15:0] cmd;
    spi_frame(make_cmd(3'd5), 16, 4);
    cmd = make_cmd(3'd3);
    @(negedge clk);
    SS_n = 1'b0;
    repeat (4) @(negedge clk);
    for (int i = 0; i < 10; i++) begin
      SCLK = 1'b0;
      MOSI = cmd[15-i];
      repeat (4) @(negedge clk);
      if (i < 9) begin
        SCLK = 1'b1;
        repeat (4) @(negedge clk);
      end
    end
    // Bit 6 of 0x0FFF is being presented here.
    vectors++;
    if (MISO !== 1'b1) begin
      errors++;
      $display("FAIL mid_frame_bit got=%b expected=1", MISO);
    end
    rst = 1'b1;
    #1;
    vectors++;
    if (MISO !== 1'b0) begin
      errors++;
      $display("FAIL reset_mid_miso got=%b expected=0", MISO);
    end
    SS_n = 1'b1; SCLK = 1'b1;
    repeat (4) @(negedge clk);
    rst = 1'b0;
    m_addr = 3'd0;
    repeat (4) @(negedge clk);
    spi_frame(make_cmd(3'd2), 16, 4);
  endtask

  task automatic test_round_robin();
    for (int k = 0; k < 6; k++)
      spi_frame(make_cmd(3'(k)), 16, 16);
  endtask

  task automatic test_random();
    int r, nb;
    for (int k = 0; k < 24; k++) begin
      r = $urandom_range(0, 9);
      if (r == 0)      nb = $urandom_range(1, 15);
      else if (r == 1) nb = $urandom_range(17, 20);
      else             nb = 16;
      spi_frame(make_cmd(3'($urandom_range(0, 7))), nb, $urandom_range(4, 9));
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_abort();
    test_ch7();
    test_long_frame();
    test_reset_mid();
    test_round_robin();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end

endmodule
